conv_result_buffer: RTL and testbench
=====================================

Name: conv_result_buffer

Overview:
Receiving end of the convolution engine's result stream. Captures one 8x10 output frame (out_valid/out_elem/out_row_end/out_last/out_row_idx/out_col_idx) into on-chip RAM and checks stream framing against the expected raster order. Tracks the frame maximum and its position. Once the frame is complete, it serves random-access reads to the display/UART layer.

Parameters:
ACC_WIDTH, 12, width of each result element (matches engine accumulator)
OUT_M, 8, output rows per frame
OUT_N, 10, output columns per frame

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
clear  input  1  pulse; discards the frame and returns to EMPTY
in_valid  input  1  result beat strobe
in_elem  input  ACC_WIDTH  result value
in_row_end  input  1  beat is last of a row
in_last  input  1  beat is last of the frame
in_row_idx  input  4  row index of the beat
in_col_idx  input  4  column index of the beat
rd_req  input  1  read request strobe
rd_row  input  4  read row address
rd_col  input  4  read column address
rd_valid  output  1  read data strobe, one cycle after an accepted rd_req
rd_data  output  ACC_WIDTH  read data
rd_err  output  1  with rd_valid: address out of range
capturing  output  1  state is CAPTURE
frame_done  output  1  level, state is FULL
elem_count  output  7  beats written this frame (0..80)
max_val  output  ACC_WIDTH  largest element so far
max_row  output  4  row of max_val
max_col  output  4  column of max_val
err_seq  output  1  sticky: index or row_end/last flag mismatch
err_frame  output  1  sticky: early in_last, or beat received while FULL

Behaviour:
- Single clock domain. Reset is asynchronous, active-low, with clock clk and reset rst_n.
- Reset values:
  - Every output is 0.
  - State is EMPTY and exp_row = exp_col = 0.
  - RAM contents are not reset.
- States:
  - EMPTY: waiting for the first beat.
  - CAPTURE: part of the frame received.
  - FULL: frame complete.
- clear: any state goes to EMPTY next cycle. Clears elem_count, max_*, err_*, expected position, rd_valid. If in_valid arrives in the same cycle, clear wins and the beat is dropped.
- Beat acceptance (in_valid=1 in EMPTY or CAPTURE):
  - Writes in_elem to RAM at exp_row*OUT_N+exp_col, using the expected position, never the supplied indices.
  - elem_count increments.
  - The expected position advances in raster order; column wraps at OUT_N-1 and row increments.
  - EMPTY goes to CAPTURE on the first beat.
- Checks per beat; any mismatch sets err_seq (sticky until clear or reset):
  - in_row_idx == exp_row and in_col_idx == exp_col.
  - in_row_end == (exp_col == OUT_N-1).
  - in_last == (exp_row == OUT_M-1 && exp_col == OUT_N-1).
- Final expected beat: written, then state goes to FULL; frame_done=1 from the next cycle.
- in_last on an earlier beat:
  - Beat is written; state goes to FULL.
  - err_frame=1 and err_seq=1.
  - elem_count holds the count received.
- in_valid while FULL: beat ignored (no write), err_frame=1.
- Max tracking: on each accepted beat, if in_elem > max_val (strict), update max_val, max_row=exp_row, max_col=exp_col. Ties keep the first occurrence. The first beat always loads, even if 0.
- Reads:
  - rd_req is accepted only in FULL; elsewhere it is ignored (no rd_valid).
  - Accepted rd_req gives rd_valid=1 for exactly one cycle, next cycle (latency 1).
  - In range: rd_data = RAM[rd_row*OUT_N+rd_col], rd_err=0.
  - rd_row >= OUT_M or rd_col >= OUT_N: rd_data=0, rd_err=1.
  - Back-to-back rd_req every cycle is supported at full throughput.
  - rd_req in the same cycle as the final write is ignored, because the state is not yet FULL.
- Widths: RAM address is 7 bits (80 entries); address arithmetic is unsigned 7-bit.

Decomposition:
- Shared package holds: OUT_M, OUT_N, ACC_WIDTH defaults, frame size 80, and state encodings EMPTY=2'd0, CAPTURE=2'd1, FULL=2'd2.
- Sub-module conv_result_ram:
  - 80 x ACC_WIDTH, synchronous write.
  - Synchronous read with 1-cycle latency.
  - No reset on contents.

Test Plan:
- Clean frame: stream 80 beats, in_elem=row*10+col with correct indices and flags -> frame_done=1, elem_count=80, err_*=0, max_val=79 at (7,9); reading (3,4) gives rd_data=34 one cycle later.
- Flag error: assert in_row_end at beat (2,5) -> err_seq=1 and stays 1; frame still completes, frame_done=1.
- Early last: in_last on beat 50 -> FULL, err_frame=1, err_seq=1, elem_count=50.
- Overrun and bad read: after a clean frame, send one extra beat -> err_frame=1, RAM unchanged; rd_req (8,0) -> rd_valid=1, rd_err=1, rd_data=0.
- Max ties: all elements 7 except 9 at (1,2) and (4,4) -> max_val=9, max_row=1, max_col=2.
- Clear/reset mid-frame: clear with in_valid at beat 30 -> EMPTY, elem_count=0, no write; a new 80-beat frame completes cleanly. Repeat with rst_n low mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/conv_result_buffer_pkg.sv
// Shared constants and state encoding for the convolution result buffer.
package conv_result_buffer_pkg;

    localparam int ACC_WIDTH_DEF = 12;
    localparam int OUT_M_DEF     = 8;
    localparam int OUT_N_DEF     = 10;
    localparam int FRAME_SIZE    = 80;
    localparam int ADDR_W        = 7;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FULL    = 2'd2
    } state_e;

endpackage

// File: rtl/conv_result_buffer_ram.sv
// Frame store: synchronous write, synchronous read with one cycle of latency.
// Contents are deliberately not reset.
module conv_result_buffer_ram
    import conv_result_buffer_pkg::*;
#(
    parameter int DATA_W = ACC_WIDTH_DEF,
    parameter int DEPTH  = FRAME_SIZE
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write port and registered read port share the clock.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_result_buffer.sv
// Captures one raster-ordered result frame, checks its framing, tracks the
// maximum element and then serves random-access reads.
//
// Stream interface: in_valid qualifies a beat; there is no back-pressure, so
// every beat is taken in the cycle it is presented. Read interface: rd_req is
// a strobe answered by rd_valid exactly one cycle later, one response per
// request, and requests may be issued every cycle.
module conv_result_buffer
    import conv_result_buffer_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int OUT_M     = OUT_M_DEF,
    parameter int OUT_N     = OUT_N_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [ACC_WIDTH-1:0] in_elem,
    input  logic                 in_row_end,
    input  logic                 in_last,
    input  logic [3:0]           in_row_idx,
    input  logic [3:0]           in_col_idx,
    input  logic                 rd_req,
    input  logic [3:0]           rd_row,
    input  logic [3:0]           rd_col,
    output logic                 rd_valid,
    output logic [ACC_WIDTH-1:0] rd_data,
    output logic                 rd_err,
    output logic                 capturing,
    output logic                 frame_done,
    output logic [6:0]           elem_count,
    output logic [ACC_WIDTH-1:0] max_val,
    output logic [3:0]           max_row,
    output logic [3:0]           max_col,
    output logic                 err_seq,
    output logic                 err_frame
);

    state_e                state_q;
    logic [3:0]            exp_row_q, exp_col_q;
    logic [6:0]            elem_count_q;
    logic [ACC_WIDTH-1:0]  max_val_q;
    logic [3:0]            max_row_q, max_col_q;
    logic                  err_seq_q, err_frame_q;
    logic                  rd_valid_q, rd_err_q;
    logic [ACC_WIDTH-1:0]  ram_rdata;

    // Beat decode: the write position is always the expected one, never the
    // indices carried by the beat.
    logic              accept;
    logic              at_row_end, at_final;
    logic              idx_bad, flag_bad;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic              rd_in_range, rd_accept;

    assign accept     = in_valid && !clear && (state_q != ST_FULL);
    assign at_row_end = (exp_col_q == 4'(OUT_N - 1));
    assign at_final   = at_row_end && (exp_row_q == 4'(OUT_M - 1));
    assign idx_bad    = (in_row_idx != exp_row_q) || (in_col_idx != exp_col_q);
    assign flag_bad   = (in_row_end != at_row_end) || (in_last != at_final);
    assign wr_addr    = 7'(exp_row_q) * 7'(OUT_N) + 7'(exp_col_q);

    assign rd_in_range = (rd_row < 4'(OUT_M)) && (rd_col < 4'(OUT_N));
    assign rd_accept   = rd_req && !clear && (state_q == ST_FULL);
    assign rd_addr     = 7'(rd_row) * 7'(OUT_N) + 7'(rd_col);

    conv_result_buffer_ram #(
        .DATA_W (ACC_WIDTH),
        .DEPTH  (FRAME_SIZE)
    ) u_ram (
        .clk     (clk),
        .we_i    (accept),
        .waddr_i (wr_addr),
        .wdata_i (in_elem),
        .re_i    (rd_accept && rd_in_range),
        .raddr_i (rd_addr),
        .rdata_o (ram_rdata)
    );

    // Capture FSM with framing checks, max tracking and read-response flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            exp_row_q    <= '0;
            exp_col_q    <= '0;
            elem_count_q <= '0;
            max_val_q    <= '0;
            max_row_q    <= '0;
            max_col_q    <= '0;
            err_seq_q    <= 1'b0;
            err_frame_q  <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_err_q     <= 1'b0;
        end else if (clear) begin
            state_q      <= ST_EMPTY;
            exp_row_q    <= '0;
            exp_col_q    <= '0;
            elem_count_q <= '0;
            max_val_q    <= '0;
            max_row_q    <= '0;
            max_col_q    <= '0;
            err_seq_q    <= 1'b0;
            err_frame_q  <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_err_q     <= 1'b0;
        end else begin
            if (accept) begin
                elem_count_q <= elem_count_q + 7'd1;
                // First beat always loads; later beats need a strict increase.
                if ((elem_count_q == 7'd0) || (in_elem > max_val_q)) begin
                    max_val_q <= in_elem;
                    max_row_q <= exp_row_q;
                    max_col_q <= exp_col_q;
                end
                if (idx_bad || flag_bad) begin
                    err_seq_q <= 1'b1;
                end
                if (at_final || in_last) begin
                    state_q   <= ST_FULL;
                    exp_row_q <= '0;
                    exp_col_q <= '0;
                    if (!at_final) begin
                        err_frame_q <= 1'b1;
                    end
                end else begin
                    state_q <= ST_CAPTURE;
                    if (at_row_end) begin
                        exp_col_q <= '0;
                        exp_row_q <= exp_row_q + 4'd1;
                    end else begin
                        exp_col_q <= exp_col_q + 4'd1;
                    end
                end
            end else if (in_valid && (state_q == ST_FULL)) begin
                err_frame_q <= 1'b1;
            end
            rd_valid_q <= rd_accept;
            rd_err_q   <= rd_accept && !rd_in_range;
        end
    end

    assign capturing  = (state_q == ST_CAPTURE);
    assign frame_done = (state_q == ST_FULL);
    assign elem_count = elem_count_q;
    assign max_val    = max_val_q;
    assign max_row    = max_row_q;
    assign max_col    = max_col_q;
    assign err_seq    = err_seq_q;
    assign err_frame  = err_frame_q;
    assign rd_valid   = rd_valid_q;
    assign rd_err     = rd_err_q;
    assign rd_data    = (rd_valid_q && !rd_err_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_conv_result_buffer.sv
// Directed bench for conv_result_buffer: clean, erroneous and interrupted
// frames, max ties, and reads in and out of range.
module tb_conv_result_buffer;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [11:0] in_elem;
    logic        in_row_end;
    logic        in_last;
    logic [3:0]  in_row_idx;
    logic [3:0]  in_col_idx;
    logic        rd_req;
    logic [3:0]  rd_row;
    logic [3:0]  rd_col;
    logic        rd_valid;
    logic [11:0] rd_data;
    logic        rd_err;
    logic        capturing;
    logic        frame_done;
    logic [6:0]  elem_count;
    logic [11:0] max_val;
    logic [3:0]  max_row;
    logic [3:0]  max_col;
    logic        err_seq;
    logic        err_frame;

    int n_checks = 0;
    int n_errors = 0;

    conv_result_buffer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_elem    (in_elem),
        .in_row_end (in_row_end),
        .in_last    (in_last),
        .in_row_idx (in_row_idx),
        .in_col_idx (in_col_idx),
        .rd_req     (rd_req),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_err     (rd_err),
        .capturing  (capturing),
        .frame_done (frame_done),
        .elem_count (elem_count),
        .max_val    (max_val),
        .max_row    (max_row),
        .max_col    (max_col),
        .err_seq    (err_seq),
        .err_frame  (err_frame)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One idle cycle; inputs change on the falling edge, outputs are sampled there too.
    task automatic idle();
        in_valid = 1'b0;
        rd_req   = 1'b0;
        clear    = 1'b0;
        @(negedge clk);
    endtask

    task automatic beat(input int r, input int c, input int e, input logic re, input logic la);
        in_valid   = 1'b1;
        in_row_idx = 4'(r);
        in_col_idx = 4'(c);
        in_elem    = 12'(e);
        in_row_end = re;
        in_last    = la;
        @(negedge clk);
        in_valid   = 1'b0;
    endtask

    // Element value patterns: 0 = r*10+c, 1 = all 7 with two 9s, 2 = r*10+c+100.
    function automatic int elem_of(input int mode, input int r, input int c);
        if (mode == 1) return ((r == 1 && c == 2) || (r == 4 && c == 4)) ? 9 : 7;
        if (mode == 2) return r * 10 + c + 100;
        return r * 10 + c;
    endfunction

    // Stream beats [start, start+count); flag_at toggles in_row_end, last_at forces in_last.
    task automatic frame(input int start, input int count, input int mode,
                         input int flag_at, input int last_at);
        for (int i = start; i < start + count; i++) begin
            beat(i / 10, i % 10, elem_of(mode, i / 10, i % 10),
                 ((i % 10) == 9) ^ (i == flag_at), (i == 79) || (i == last_at));
        end
    endtask

    // Issue one read; outputs sampled on the following falling edge are the response.
    task automatic read(input int r, input int c);
        rd_req = 1'b1;
        rd_row = 4'(r);
        rd_col = 4'(c);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_valid"},   32'(rd_valid),   0);
        check({tag, "_rd_data"},    32'(rd_data),    0);
        check({tag, "_rd_err"},     32'(rd_err),     0);
        check({tag, "_capturing"},  32'(capturing),  0);
        check({tag, "_frame_done"}, 32'(frame_done), 0);
        check({tag, "_elem_count"}, 32'(elem_count), 0);
        check({tag, "_max_val"},    32'(max_val),    0);
        check({tag, "_max_row"},    32'(max_row),    0);
        check({tag, "_max_col"},    32'(max_col),    0);
        check({tag, "_err_seq"},    32'(err_seq),    0);
        check({tag, "_err_frame"},  32'(err_frame),  0);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_elem = '0;
        in_row_end = 1'b0; in_last = 1'b0; in_row_idx = '0; in_col_idx = '0;
        rd_req = 1'b0; rd_row = '0; rd_col = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle();

        // Clean frame
        frame(0, 80, 0, -1, -1);
        check("clean_frame_done", 32'(frame_done), 1);
        check("clean_capturing",  32'(capturing),  0);
        check("clean_count",      32'(elem_count), 80);
        check("clean_err_seq",    32'(err_seq),    0);
        check("clean_err_frame",  32'(err_frame),  0);
        check("clean_max_val",    32'(max_val),    79);
        check("clean_max_row",    32'(max_row),    7);
        check("clean_max_col",    32'(max_col),    9);
        read(3, 4);
        check("rd34_valid", 32'(rd_valid), 1);
        check("rd34_data",  32'(rd_data),  34);
        check("rd34_err",   32'(rd_err),   0);
        read(7, 9);
        check("rd79_b2b_valid", 32'(rd_valid), 1);
        check("rd79_b2b_data",  32'(rd_data),  79);
        idle();
        check("rd_one_cycle", 32'(rd_valid), 0);

        // Overrun beat while FULL, then reads in and out of range
        beat(0, 0, 123, 1'b0, 1'b0);
        check("overrun_err_frame", 32'(err_frame),  1);
        check("overrun_count",     32'(elem_count), 80);
        check("overrun_err_seq",   32'(err_seq),    0);
        read(0, 0);
        check("overrun_ram_kept", 32'(rd_data), 0);
        check("overrun_rd_err",   32'(rd_err),  0);
        read(8, 0);
        check("bad_row_valid", 32'(rd_valid), 1);
        check("bad_row_err",   32'(rd_err),   1);
        check("bad_row_data",  32'(rd_data),  0);
        read(0, 12);
        check("bad_col_err",  32'(rd_err),  1);
        check("bad_col_data", 32'(rd_data), 0);
        idle();

        do_clear();
        check_all_zero("clear");

        // Flag error: spurious in_row_end at (2,5)
        frame(0, 26, 0, 25, -1);
        check("flag_err_seq_now", 32'(err_seq), 1);
        frame(26, 54, 0, -1, -1);
        check("flag_err_seq_sticky", 32'(err_seq),    1);
        check("flag_frame_done",     32'(frame_done), 1);
        check("flag_err_frame",      32'(err_frame),  0);
        do_clear();

        // Early in_last on the 50th beat
        frame(0, 50, 0, -1, 49);
        check("early_frame_done", 32'(frame_done), 1);
        check("early_err_frame",  32'(err_frame),  1);
        check("early_err_seq",    32'(err_seq),    1);
        check("early_count",      32'(elem_count), 50);
        check("early_max_val",    32'(max_val),    49);
        do_clear();

        // Max ties keep the first occurrence
        frame(0, 80, 1, -1, -1);
        check("tie_max_val", 32'(max_val), 9);
        check("tie_max_row", 32'(max_row), 1);
        check("tie_max_col", 32'(max_col), 2);
        read(4, 4);
        check("tie_rd44", 32'(rd_data), 9);
        idle();
        do_clear();

        // Clear mid-frame with a simultaneous beat
        frame(0, 30, 0, -1, -1);
        check("mid_capturing", 32'(capturing),  1);
        check("mid_not_done",  32'(frame_done), 0);
        check("mid_count",     32'(elem_count), 30);
        read(0, 0);
        check("rd_in_capture_ignored", 32'(rd_valid), 0);
        clear = 1'b1;
        beat(3, 0, 30, 1'b0, 1'b0);
        clear = 1'b0;
        check("clr_capturing", 32'(capturing),  0);
        check("clr_count",     32'(elem_count), 0);
        idle();
        check("clr_count_hold", 32'(elem_count), 0);
        frame(0, 80, 2, -1, -1);
        check("after_clr_done",    32'(frame_done), 1);
        check("after_clr_count",   32'(elem_count), 80);
        check("after_clr_err_seq", 32'(err_seq),    0);
        check("after_clr_max_val", 32'(max_val),    179);
        read(3, 0);
        check("after_clr_rd30", 32'(rd_data), 130);
        idle();
        do_clear();

        // Asynchronous reset mid-frame
        frame(0, 20, 0, -1, -1);
        check("pre_rst_count", 32'(elem_count), 20);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        frame(0, 80, 0, -1, -1);
        check("post_rst_done",    32'(frame_done), 1);
        check("post_rst_count",   32'(elem_count), 80);
        check("post_rst_err_seq", 32'(err_seq),    0);
        check("post_rst_err_frm", 32'(err_frame),  0);
        read(6, 7);
        check("post_rst_rd67", 32'(rd_data), 67);
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
